// File: rtl/flag_unit_pkg.sv
// Shared flag-pipeline types: NZCV bit indices, the pending-stage entry
// and the masked-overlay helper used for both commit and forwarding.
package flag_unit_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic       valid;
    logic [3:0] mask;
    logic [3:0] flags;
  } flag_entry_t;

  // Replace the bits of base selected by the entry mask, only if the entry is valid.
  function automatic logic [3:0] flag_overlay(input logic [3:0] base, input flag_entry_t e);
    logic [3:0] m;
    m = e.valid ? e.mask : 4'b0000;
    return (base & ~m) | (e.flags & m);
  endfunction

endpackage

// File: rtl/flag_stage.sv
// One pending flag-update register. kill beats load; neither means hold.
module flag_stage
  import flag_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        kill,
  input  flag_entry_t d,
  output flag_entry_t q
);

  // Stage register: cleared by kill, captures d on load, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (kill) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/flag_unit.sv
// Condition-flag producer: builds NZCV updates from EX results or MSR
// writes, carries them through two pending stages and commits to CPSR.
// cpsr_fwd gives the condition checker the newest view of the flags.
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  input  logic [3:0]       flag_we,
  input  logic             msr_we,
  input  logic [3:0]       msr_data,
  input  logic             stall,
  input  logic             flush,
  input  logic             exc_enter,
  input  logic             exc_return,
  output logic [3:0]       cpsr,
  output logic [3:0]       cpsr_fwd,
  output logic [3:0]       spsr,
  output logic             pending
);

  flag_entry_t entry;
  flag_entry_t s1;
  flag_entry_t s2;
  logic        exc_any;
  logic [3:0]  alu_nzcv;
  logic [3:0]  enter_value;

  assign exc_any = exc_enter | exc_return;

  // Entry selection: an explicit CPSR write takes priority over an ALU result.
  always_comb begin
    entry              = '0;
    alu_nzcv           = 4'b0000;
    alu_nzcv[FLAG_N]   = alu_result[WIDTH-1];
    alu_nzcv[FLAG_Z]   = (alu_result == '0);
    alu_nzcv[FLAG_C]   = alu_carry;
    alu_nzcv[FLAG_V]   = alu_ovf;
    if (msr_we) begin
      entry.valid = 1'b1;
      entry.mask  = 4'hF;
      entry.flags = msr_data;
    end else if (alu_valid) begin
      entry.valid = 1'b1;
      entry.mask  = flag_we;
      entry.flags = alu_nzcv;
    end
  end

  // S1 is killed by flush even while stalled; exceptions empty the pipe.
  flag_stage u_s1 (
    .clk  (clk),
    .rst  (rst),
    .load (!stall),
    .kill (exc_any | flush),
    .d    (entry),
    .q    (s1)
  );

  // S2 receives an invalid entry on flush, but only when the pipe advances.
  flag_stage u_s2 (
    .clk  (clk),
    .rst  (rst),
    .load (!stall),
    .kill (exc_any | (flush & !stall)),
    .d    (s1),
    .q    (s2)
  );

  assign enter_value = flag_overlay(cpsr, s2);

  // Architectural CPSR/SPSR: exception entry commits S2 and saves the result,
  // return restores SPSR, otherwise S2 commits whenever the pipe advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpsr <= 4'b0000;
      spsr <= 4'b0000;
    end else if (exc_enter) begin
      cpsr <= enter_value;
      spsr <= enter_value;
    end else if (exc_return) begin
      cpsr <= spsr;
    end else if (!stall) begin
      cpsr <= enter_value;
    end
  end

  // Forwarded flags: architectural value, then older S2, then newest S1.
  always_comb begin
    cpsr_fwd = flag_overlay(flag_overlay(cpsr, s2), s1);
    pending  = s1.valid | s2.valid;
  end

endmodule
